// File: rtl/dmem_watch.sv
// Byte-lane data memory with a registered read port and a debounced watch cursor for the display.
// Define DMEM_ERR_EN to reject misaligned or out-of-range requests.
module dmem_watch #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int WATCH_BASE = 0,
    parameter int NUM_WATCH  = 4,
    parameter int DEBOUNCE   = 16
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 mem_write,
    input  logic                                                 mem_read,
    input  logic [WIDTH/8-1:0]                                   byte_en,
    input  logic [WIDTH-1:0]                                     read_address,
    input  logic [WIDTH-1:0]                                     write_address,
    input  logic [WIDTH-1:0]                                     write_data,
    output logic [WIDTH-1:0]                                     mem_data,
    output logic                                                 rd_valid,
    output logic                                                 err,
    input  logic                                                 button_up,
    input  logic                                                 button_down,
    output logic [(NUM_WATCH > 1 ? $clog2(NUM_WATCH) : 1)-1:0]   watch_idx,
    output logic [WIDTH-1:0]                                     display_data
);

    localparam int NB  = WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);
    localparam int WI  = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;
    localparam int CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rd_idx, wr_idx, watch_addr;
    logic          rd_bad, wr_bad;
    logic          do_read, do_write, err_next;

    assign rd_idx     = read_address[LSB +: AW];
    assign wr_idx     = write_address[LSB +: AW];
    assign watch_addr = AW'(WATCH_BASE) + AW'(watch_idx);

`ifdef DMEM_ERR_EN
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((1 << LSB) - 1);

    // Misaligned, or any bit above the word index set, means the address lies outside the array.
    function automatic logic addr_bad(input logic [WIDTH-1:0] a);
        return ((a & LOW_MASK) != '0) || ((a >> (LSB + AW)) != '0);
    endfunction

    assign rd_bad = addr_bad(read_address);
    assign wr_bad = addr_bad(write_address);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{read_address, write_address};
    assign rd_bad = 1'b0;
    assign wr_bad = 1'b0;
`endif

    assign do_read  = mem_read  & ~mem_write & ~rd_bad;
    assign do_write = mem_write & ~mem_read  & ~wr_bad;
    assign err_next = (mem_read & mem_write)
                    | (mem_read  & ~mem_write & rd_bad)
                    | (mem_write & ~mem_read  & wr_bad);

    // NOTE: the array has no reset branch so it maps onto block RAM; its contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) mem[wr_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]    raw, lvl, set;
    logic [CW-1:0] cnt [2];

    assign raw = {button_down, button_up};

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            set[b] = raw[b] & ~lvl[b] & (cnt[b] == CW'(DEBOUNCE - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data     <= '0;
            rd_valid     <= 1'b0;
            err          <= 1'b0;
            watch_idx    <= '0;
            display_data <= '0;
            lvl          <= '0;
            for (int b = 0; b < 2; b++) cnt[b] <= '0;
        end else begin
            rd_valid <= do_read;
            err      <= err_next;
            if (do_read) mem_data <= mem[rd_idx];
            display_data <= mem[watch_addr];

            for (int b = 0; b < 2; b++) begin
                if (raw[b] == lvl[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CW'(DEBOUNCE - 1)) begin
                    lvl[b] <= raw[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end

            // Any overlap between the two buttons recentres the cursor.
            if ((set[0] && (set[1] || lvl[1])) || (set[1] && lvl[0])) begin
                watch_idx <= '0;
            end else if (set[0]) begin
                watch_idx <= (watch_idx == WI'(NUM_WATCH - 1)) ? '0 : watch_idx + 1'b1;
            end else if (set[1]) begin
                watch_idx <= (watch_idx == '0) ? WI'(NUM_WATCH - 1) : watch_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_watch.sv
// Directed bench for dmem_watch: byte writes, read handshake, conflicts, address checks, watch cursor.
// Exercises DMEM_ERR_EN behaviour when that macro is defined, truncation otherwise.
module tb_dmem_watch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write, mem_read;
    logic [3:0]  byte_en;
    logic [31:0] read_address, write_address, write_data;
    logic [31:0] mem_data, display_data;
    logic        rd_valid, err;
    logic        button_up, button_down;
    logic [1:0]  watch_idx;

    int checks = 0;
    int errors = 0;

    dmem_watch #(
        .WIDTH(32), .DEPTH(1024), .WATCH_BASE(1), .NUM_WATCH(4), .DEBOUNCE(4)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_write(mem_write), .mem_read(mem_read), .byte_en(byte_en),
        .read_address(read_address), .write_address(write_address), .write_data(write_data),
        .mem_data(mem_data), .rd_valid(rd_valid), .err(err),
        .button_up(button_up), .button_down(button_down),
        .watch_idx(watch_idx), .display_data(display_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_write = 1'b1; write_address = a; write_data = d; byte_en = be;
        tick();
        mem_write = 1'b0; byte_en = 4'h0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_read = 1'b1; read_address = a;
        tick();
        check({tag, " data"}, mem_data, exp);
        check({tag, " rd_valid"}, {31'b0, rd_valid}, 32'd1);
        check({tag, " err"}, {31'b0, err}, 32'd0);
        mem_read = 1'b0;
        tick();
        check({tag, " rd_valid drop"}, {31'b0, rd_valid}, 32'd0);
        check({tag, " data hold"}, mem_data, exp);
    endtask

    task automatic press(input logic up, input logic down);
        button_up = up; button_down = down;
        repeat (6) tick();
        button_up = 1'b0; button_down = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0; byte_en = 4'h0;
        read_address = '0; write_address = '0; write_data = '0;
        button_up = 1'b0; button_down = 1'b0;
        tick(); tick();
        check("reset mem_data", mem_data, 32'h0);
        check("reset rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset err", {31'b0, err}, 32'd0);
        check("reset watch_idx", {30'b0, watch_idx}, 32'd0);
        check("reset display", display_data, 32'h0);
        reset = 1'b0;

        // Full-word write then read, then byte-lane updates.
        wr(32'h10, 32'hDEADBEEF, 4'b1111);
        rd_check("full word", 32'h10, 32'hDEADBEEF);
        wr(32'h10, 32'h000000AA, 4'b0001);
        rd_check("lane0", 32'h10, 32'hDEADBEAA);
        wr(32'h10, 32'hFFFFFFFF, 4'b0000);
        rd_check("no lanes", 32'h10, 32'hDEADBEAA);
        wr(32'h10, 32'h11223344, 4'b1010);
        rd_check("lanes 1,3", 32'h10, 32'h11AD33AA);

        // Simultaneous read and write: rejected, memory untouched.
        mem_write = 1'b1; mem_read = 1'b1; read_address = 32'h10; write_address = 32'h10;
        write_data = 32'h0; byte_en = 4'hF;
        tick();
        check("conflict err", {31'b0, err}, 32'd1);
        check("conflict rd_valid", {31'b0, rd_valid}, 32'd0);
        mem_write = 1'b0; mem_read = 1'b0; byte_en = 4'h0;
        tick();
        check("conflict err drop", {31'b0, err}, 32'd0);
        rd_check("after conflict", 32'h10, 32'h11AD33AA);

        // Read right after write, then back-to-back reads.
        mem_write = 1'b1; write_address = 32'h8; write_data = 32'h12345678; byte_en = 4'hF;
        tick();
        mem_write = 1'b0; byte_en = 4'h0;
        mem_read = 1'b1; read_address = 32'h8;
        tick();
        check("raw data", mem_data, 32'h12345678);
        check("raw rd_valid", {31'b0, rd_valid}, 32'd1);
        read_address = 32'h10;
        tick();
        check("b2b data", mem_data, 32'h11AD33AA);
        check("b2b rd_valid", {31'b0, rd_valid}, 32'd1);
        mem_read = 1'b0;
        tick();
        check("b2b rd_valid drop", {31'b0, rd_valid}, 32'd0);

        wr(32'h0, 32'h0BADF00D, 4'hF);
`ifdef DMEM_ERR_EN
        mem_read = 1'b1; read_address = 32'h12;
        tick();
        check("misaligned rd err", {31'b0, err}, 32'd1);
        check("misaligned rd_valid", {31'b0, rd_valid}, 32'd0);
        check("misaligned hold", mem_data, 32'h11AD33AA);
        mem_read = 1'b0;
        tick();
        wr(32'h1000, 32'h00000055, 4'hF);
        check("range wr err", {31'b0, err}, 32'd1);
        tick();
        check("range err drop", {31'b0, err}, 32'd0);
        rd_check("range untouched", 32'h0, 32'h0BADF00D);
`else
        rd_check("truncated low", 32'h12, 32'h11AD33AA);
        wr(32'h1000, 32'h00000055, 4'hF);
        check("truncated wr err", {31'b0, err}, 32'd0);
        rd_check("truncated high", 32'h0, 32'h00000055);
`endif

        // Watched word at cursor 2 is mem[3] (byte address 0xC).
        wr(32'hC, 32'd5678, 4'hF);

        repeat (3) begin
            button_up = 1'b1; tick(); tick();
            button_up = 1'b0; tick(); tick();
        end
        check("bounce ignored", {30'b0, watch_idx}, 32'd0);
        button_up = 1'b1;
        repeat (6) tick();
        check("up held", {30'b0, watch_idx}, 32'd1);
        button_up = 1'b0;
        repeat (6) tick();
        check("up released", {30'b0, watch_idx}, 32'd1);

        press(1'b0, 1'b1);
        check("down 1->0", {30'b0, watch_idx}, 32'd0);
        press(1'b0, 1'b1);
        check("down wrap 0->3", {30'b0, watch_idx}, 32'd3);
        press(1'b1, 1'b0);
        check("up wrap 3->0", {30'b0, watch_idx}, 32'd0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("up to 2", {30'b0, watch_idx}, 32'd2);
        check("display 5678", display_data, 32'd5678);

        wr(32'hC, 32'hFFFFE9D2, 4'hF);
        check("display lag", display_data, 32'd5678);
        tick();
        check("display -5678", display_data, 32'hFFFFE9D2);

        press(1'b1, 1'b1);
        check("both pressed", {30'b0, watch_idx}, 32'd0);

        press(1'b1, 1'b0);
        button_up = 1'b1;
        repeat (6) tick();
        check("up held to 2", {30'b0, watch_idx}, 32'd2);
        button_down = 1'b1;
        repeat (6) tick();
        check("down while up high", {30'b0, watch_idx}, 32'd0);
        button_up = 1'b0; button_down = 1'b0;
        repeat (6) tick();

        // Reset in the middle of a debounce and a read.
        press(1'b1, 1'b0);
        check("pre-reset idx", {30'b0, watch_idx}, 32'd1);
        button_up = 1'b1; mem_read = 1'b1; read_address = 32'h10;
        tick();
        check("pre-reset rd_valid", {31'b0, rd_valid}, 32'd1);
        reset = 1'b1; mem_read = 1'b0;
        tick();
        check("mid reset rd_valid", {31'b0, rd_valid}, 32'd0);
        check("mid reset mem_data", mem_data, 32'h0);
        check("mid reset idx", {30'b0, watch_idx}, 32'd0);
        check("mid reset display", display_data, 32'h0);
        reset = 1'b0;
        repeat (3) tick();
        check("debounce restarted", {30'b0, watch_idx}, 32'd0);
        tick();
        check("debounce completes", {30'b0, watch_idx}, 32'd1);
        button_up = 1'b0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
